// File: rtl/group_scheduler_pkg.sv
// Shared types and constants for the level-0 group scheduler.
// Also holds small helpers for flat-index arithmetic.
package lib_arbiter_pkg;

    localparam int DEF_GRP_ROWS = 4;
    localparam int DEF_GRP_COLS = 4;
    localparam int NUM_GRP      = DEF_GRP_ROWS * DEF_GRP_COLS;
    localparam int IDX_W        = $clog2(NUM_GRP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } sched_state_t;

    function automatic int idx_row(input int idx, input int cols);
        return idx / cols;
    endfunction

    function automatic int idx_col(input int idx, input int cols);
        return idx % cols;
    endfunction

endpackage

// File: rtl/group_scheduler_if.sv
// Request/grant bundle between the level-0 groups and the group scheduler.
// The scheduler sits on the slave modport; the group array drives the master side.
interface group_sched_if #(
    parameter int GRP_ROWS = 4,
    parameter int GRP_COLS = 4,
    parameter int GRP_ADD  = 2
);
    logic [GRP_ROWS-1:0][GRP_COLS-1:0] req_i;
    logic                              grp_release_i;
    logic                              hold_i;
    logic [GRP_ROWS-1:0][GRP_COLS-1:0] enable_o;
    logic [GRP_ADD-1:0]                grp_x_o;
    logic [GRP_ADD-1:0]                grp_y_o;
    logic                              grp_valid_o;
    logic                              timeout_o;
    logic                              active_o;

    modport slave (
        input  req_i, grp_release_i, hold_i,
        output enable_o, grp_x_o, grp_y_o, grp_valid_o, timeout_o, active_o
    );

    modport master (
        output req_i, grp_release_i, hold_i,
        input  enable_o, grp_x_o, grp_y_o, grp_valid_o, timeout_o, active_o
    );
endinterface

// File: rtl/group_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
// The request vector is doubled so the wrap becomes a plain lowest-bit search.
module rr_pick #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [2*N-1:0] masked;
    logic [IW:0]    pos;

    always_comb begin
        masked  = {req_i, req_i} & ({(2*N){1'b1}} << ptr_i);
        pos     = '0;
        found_o = 1'b0;
        // Descending scan so the lowest set bit is the one that sticks.
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) begin
                pos     = (IW+1)'(i);
                found_o = 1'b1;
            end
        end
        idx_o = (pos >= N_W) ? IW'(pos - N_W) : IW'(pos);
    end
endmodule

// File: rtl/group_scheduler.sv
// Round-robin scheduler granting one level-0 group at a time, with a watchdog
// that force-releases a grant held too long.
module group_scheduler
    import lib_arbiter_pkg::*;
#(
    parameter int GRP_ROWS = DEF_GRP_ROWS,
    parameter int GRP_COLS = DEF_GRP_COLS,
    parameter int GRP_ADD  = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    group_sched_if.slave bus
);
    localparam int N    = GRP_ROWS * GRP_COLS;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    sched_state_t    state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gidx_q;
    logic [WD_W-1:0] wd_q;
    logic [N-1:0]    enable_q;
    logic [GRP_ADD-1:0] x_q;
    logic [GRP_ADD-1:0] y_q;
    logic            valid_q;
    logic            timeout_q;

    logic [N-1:0]    req_flat;
    logic [IW-1:0]   next_ptr;
    logic [IW-1:0]   pick_ptr;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    pick_onehot;
    logic [GRP_ADD-1:0] pick_x;
    logic [GRP_ADD-1:0] pick_y;
    logic            rel_exit;
    logic            abort_exit;
    logic            tmo_exit;
    logic            busy_exit;
    logic            can_grant;

    for (genvar gi = 0; gi < GRP_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < GRP_COLS; gj++) begin : g_col
            assign req_flat[gi*GRP_COLS+gj]     = bus.req_i[gi][gj];
            assign bus.enable_o[gi][gj]         = enable_q[gi*GRP_COLS+gj];
        end
    end

    // While busy, the next winner is searched from just past the current grant,
    // so a back-to-back regrant already honours the updated pointer.
    always_comb begin
        next_ptr    = (gidx_q == IW'(N-1)) ? '0 : gidx_q + 1'b1;
        pick_ptr    = (state_q == BUSY) ? next_ptr : ptr_q;
        rel_exit    = (state_q == BUSY) && bus.grp_release_i;
        abort_exit  = (state_q == BUSY) && !req_flat[gidx_q];
        tmo_exit    = (state_q == BUSY) && (wd_q == WD_W'(TIMEOUT-1));
        busy_exit   = rel_exit || abort_exit || tmo_exit;
        can_grant   = pick_found && !bus.hold_i;
        pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
        pick_x      = GRP_ADD'(idx_row(int'(pick_idx), GRP_COLS));
        pick_y      = GRP_ADD'(idx_col(int'(pick_idx), GRP_COLS));
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i   (req_flat),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            wd_q      <= '0;
            enable_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (can_grant) begin
                        state_q  <= GRANT;
                        gidx_q   <= pick_idx;
                        enable_q <= pick_onehot;
                        x_q      <= pick_x;
                        y_q      <= pick_y;
                        valid_q  <= 1'b1;
                    end
                end
                GRANT: begin
                    wd_q    <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (busy_exit) begin
                        ptr_q     <= next_ptr;
                        timeout_q <= tmo_exit && !rel_exit && !abort_exit;
                        if (can_grant) begin
                            state_q  <= GRANT;
                            gidx_q   <= pick_idx;
                            enable_q <= pick_onehot;
                            x_q      <= pick_x;
                            y_q      <= pick_y;
                            valid_q  <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            enable_q <= '0;
                            x_q      <= '0;
                            y_q      <= '0;
                            valid_q  <= 1'b0;
                        end
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    enable_q <= '0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grp_x_o     = x_q;
    assign bus.grp_y_o     = y_q;
    assign bus.grp_valid_o = valid_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.active_o    = (state_q != IDLE);
endmodule

// File: tb/tb_group_scheduler.sv
// Randomised and directed bench for group_scheduler against a transaction-level
// model that tracks the current grant, its age and the search pointer.
module tb_group_scheduler;
    localparam int R   = 4;
    localparam int C   = 4;
    localparam int A   = 2;
    localparam int TMO = 64;
    localparam int N   = R * C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0] req_v;
    logic         rel_v;
    logic         hold_v;

    group_sched_if #(.GRP_ROWS(R), .GRP_COLS(C), .GRP_ADD(A)) bus ();

    assign bus.req_i         = req_v;
    assign bus.grp_release_i = rel_v;
    assign bus.hold_i        = hold_v;

    group_scheduler #(.GRP_ROWS(R), .GRP_COLS(C), .GRP_ADD(A), .TIMEOUT(TMO)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: m_cur = granted group (-1 none); m_age = cycles since grant edge.
    int m_cur = -1;
    int m_age = 0;
    int m_ptr = 0;
    bit m_tmo = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic model_step();
        int nx;
        bit rel_e, ab, to;
        m_tmo = 1'b0;
        if (rst) begin
            m_cur = -1; m_ptr = 0; m_age = 0;
        end else if (m_cur < 0) begin
            nx = pick(req_v, m_ptr);
            if (!hold_v && nx >= 0) begin m_cur = nx; m_age = 0; end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            rel_e = rel_v;
            ab    = !req_v[m_cur];
            to    = (m_age == TMO);
            if (rel_e || ab || to) begin
                m_tmo = to && !rel_e && !ab;
                m_ptr = (m_cur + 1) % N;
                m_cur = -1;
                nx = pick(req_v, m_ptr);
                if (!hold_v && nx >= 0) begin m_cur = nx; m_age = 0; end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] exp_en;
        @(posedge clk);
        model_step();
        #1;
        exp_en = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
        check("enable",  bus.enable_o,    exp_en);
        check("grp_x",   bus.grp_x_o,     (m_cur >= 0) ? m_cur / C : 0);
        check("grp_y",   bus.grp_y_o,     (m_cur >= 0) ? m_cur % C : 0);
        check("valid",   bus.grp_valid_o, m_cur >= 0);
        check("timeout", bus.timeout_o,   m_tmo);
        check("active",  bus.active_o,    m_cur >= 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int order[$];
        int idle_cnt, tmo_cnt, k, prev;
        req_v = '0; rel_v = 1'b0; hold_v = 1'b0; rst = 1'b1;
        cycle(); cycle();
        check("rst_valid", bus.grp_valid_o, 0);
        rst = 1'b0;

        // Single requester at row 1, col 2.
        req_v[1*C+2] = 1'b1;
        cycle();
        check("t1_x", bus.grp_x_o, 1);
        check("t1_y", bus.grp_y_o, 2);
        check("t1_en", bus.enable_o[1][2], 1);
        repeat (5) cycle();
        rel_v = 1'b1; req_v = '0;
        cycle();
        rel_v = 1'b0;
        check("t1_off", bus.enable_o, 0);

        // All requesting, release on the 3rd busy cycle: strict 0..15,0 order.
        do_reset();
        req_v = '1; idle_cnt = 0; prev = -1;
        for (int i = 0; i < 400 && order.size() < 17; i++) begin
            rel_v = (m_cur >= 0 && m_age == 3);
            cycle();
            if (order.size() > 0 && !bus.grp_valid_o) idle_cnt++;
            k = onehot_idx(bus.enable_o);
            if (k >= 0 && k != prev) order.push_back(k);
            prev = k;
        end
        rel_v = 1'b0;
        check("t2_count", order.size(), 17);
        for (int i = 0; i < order.size(); i++) check("t2_order", order[i], i % N);
        check("t2_idle", idle_cnt, 0);
        req_v = '0; repeat (3) cycle();

        // Watchdog on idx 4; idx 5 follows directly.
        do_reset();
        req_v[4] = 1'b1; req_v[5] = 1'b1;
        cycle();
        check("t3_first", bus.enable_o[1][0], 1);
        tmo_cnt = 0;
        repeat (70) begin
            cycle();
            if (bus.timeout_o) begin
                tmo_cnt++;
                check("t3_next", bus.enable_o[1][1], 1);
            end
        end
        check("t3_pulses", tmo_cnt, 1);
        req_v = '0; repeat (3) cycle();

        // Release coinciding with the watchdog limit suppresses the pulse.
        do_reset();
        req_v[4] = 1'b1;
        cycle();
        for (int i = 0; i < 200 && !(m_cur >= 0 && m_age == TMO); i++) cycle();
        rel_v = 1'b1;
        cycle();
        check("t4_no_tmo", bus.timeout_o, 0);
        rel_v = 1'b0; req_v = '0;
        repeat (3) cycle();

        // Request drop on idx 7: next search starts at 8, so 9 beats 3.
        do_reset();
        req_v[7] = 1'b1;
        repeat (3) cycle();
        req_v = '0; req_v[3] = 1'b1; req_v[9] = 1'b1;
        cycle();
        check("t4_abort_next", bus.grp_x_o * C + bus.grp_y_o, 9);
        req_v = '0; repeat (3) cycle();

        // hold_i blocks new grants only.
        do_reset();
        hold_v = 1'b1; req_v[2] = 1'b1;
        repeat (4) begin cycle(); check("t5_hold", bus.grp_valid_o, 0); end
        hold_v = 1'b0;
        cycle();
        check("t5_grant", bus.grp_valid_o, 1);
        req_v[10] = 1'b1;
        repeat (2) cycle();
        hold_v = 1'b1; rel_v = 1'b1;
        cycle();
        rel_v = 1'b0;
        check("t5_busy_hold", bus.grp_valid_o, 0);
        repeat (3) begin cycle(); check("t5_still_held", bus.grp_valid_o, 0); end
        hold_v = 1'b0;
        cycle();
        check("t5_resume", bus.enable_o[2][2], 1);
        req_v = '0; repeat (3) cycle();

        // Reset mid-grant clears everything; search restarts from 0.
        do_reset();
        req_v[5] = 1'b1;
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_en", bus.enable_o, 0);
        check("t6_active", bus.active_o, 0);
        check("t6_tmo", bus.timeout_o, 0);
        req_v = '0; req_v[0] = 1'b1; req_v[10] = 1'b1;
        cycle();
        check("t6_first", bus.enable_o[0][0], 1);
        req_v = '0; repeat (3) cycle();

        // Random traffic: busy phase, then a slow-release phase to reach timeouts.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) req_v = N'($urandom);
            if (i < 1500) rel_v = ($urandom_range(0, 7) == 0);
            else          rel_v = ($urandom_range(0, 199) == 0);
            hold_v = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0; rel_v = 1'b0; hold_v = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
